// File: rtl/sha256_pkg.sv
// Shared constants, reader state encoding and window helpers for the
// SHA-256 message-schedule consumer.
package sha256_pkg;

  localparam int WORD_W     = 32;
  localparam int WIN_W      = 128;
  localparam int ROUNDS_DEF = 64;
  localparam int ROUND_W    = 6;
  localparam int TAG_W      = ROUND_W + WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_UNPACK = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } rd_state_e;

  // Word idx of a window; idx 0 is the oldest word in the top 32 bits.
  function automatic logic [WORD_W-1:0] win_word(input logic [WIN_W-1:0] win,
                                                 input logic [1:0]       idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = win[127:96];
      2'd1:    w = win[95:64];
      2'd2:    w = win[63:32];
      default: w = win[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_w_window_reader_if.sv
// Handshake bundle between the schedule pipeline, the window reader and the
// compression core.
interface sha256_w_window_reader_if;
  import sha256_pkg::*;

  logic               start;
  logic               win_valid;
  logic [WIN_W-1:0]   win_data;
  logic               win_ready;
  logic               w_valid;
  logic [WORD_W-1:0]  w_data;
  logic [ROUND_W-1:0] w_round;
  logic               w_last;
  logic               w_ready;
  logic               busy;
  logic               done;

  modport slave (
    input  start, win_valid, win_data, w_ready,
    output win_ready, w_valid, w_data, w_round, w_last, busy, done
  );

  modport master (
    output start, win_valid, win_data, w_ready,
    input  win_ready, w_valid, w_data, w_round, w_last, busy, done
  );

endinterface

// File: rtl/sha256_word_fifo.sv
// Synchronous FIFO with fall-through read port; a separate occupancy count
// distinguishes full from empty so pointers can wrap freely.
module sha256_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the entry is not occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/sha256_w_window_reader.sv
// Serializes 128-bit schedule windows into one tagged W_t word per round:
// the first window supplies W0..W3, every later window contributes its newest word.
module sha256_w_window_reader
  import sha256_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ROUNDS     = ROUNDS_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  sha256_w_window_reader_if.slave   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [6:0]         PUSH_ONE  = 7'd1;
  localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(ROUNDS - 1);

  rd_state_e         state_q, state_d;
  logic [6:0]        push_cnt_q, push_cnt_d;
  logic [WIN_W-1:0]  unpack_q, unpack_d;
  logic [TAG_W-1:0]  hold_q, hold_d;
  logic              done_q, done_d;

  logic              push_s, pop_s, full_s, empty_s;
  logic [TAG_W-1:0]  push_data_s, rd_data_s;
  logic [CNT_W-1:0]  count_s;
  logic              win_ready_s, win_hs_s, last_pop_s;

  sha256_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TAG_W)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .rd_data   (rd_data_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Ready depends only on registered state and FIFO flags, never on inputs.
  always_comb begin
    win_ready_s = 1'b0;
    case (state_q)
      ST_FIRST:  win_ready_s = (count_s <= CNT_W'(FIFO_DEPTH - 4));
      ST_STREAM: win_ready_s = ~full_s & (push_cnt_q < 7'(ROUNDS));
      default:   win_ready_s = 1'b0;
    endcase
    win_hs_s   = bus.win_valid & win_ready_s;
    pop_s      = bus.w_ready & ~empty_s;
    last_pop_s = pop_s & (rd_data_s[TAG_W-1:WORD_W] == LAST_RND);
  end

  // Block sequencing and FIFO push generation.
  always_comb begin
    state_d     = state_q;
    push_cnt_d  = push_cnt_q;
    unpack_d    = unpack_q;
    push_s      = 1'b0;
    push_data_s = {TAG_W{1'b0}};
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_FIRST;
          push_cnt_d = 7'd0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_FIRST: begin
        if (win_hs_s) begin
          unpack_d = bus.win_data;
          state_d  = ST_UNPACK;
        end else begin
          state_d  = ST_FIRST;
        end
      end
      ST_UNPACK: begin
        // Space for all four words was reserved before the window was taken.
        push_s      = 1'b1;
        push_data_s = {push_cnt_q[ROUND_W-1:0], win_word(unpack_q, push_cnt_q[1:0])};
        push_cnt_d  = push_cnt_q + PUSH_ONE;
        if (push_cnt_q[1:0] == 2'd3) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_UNPACK;
        end
      end
      ST_STREAM: begin
        if (win_hs_s) begin
          push_s      = 1'b1;
          push_data_s = {push_cnt_q[ROUND_W-1:0], bus.win_data[WORD_W-1:0]};
          push_cnt_d  = push_cnt_q + PUSH_ONE;
          if (push_cnt_q == 7'(ROUNDS - 1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STREAM;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (last_pop_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (pop_s) begin
      hold_d = rd_data_s;
    end else begin
      hold_d = hold_q;
    end
  end

  // Controller state, unpack buffer and the last-delivered word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      push_cnt_q <= 7'd0;
      unpack_q   <= {WIN_W{1'b0}};
      hold_q     <= {TAG_W{1'b0}};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_cnt_q <= push_cnt_d;
      unpack_q   <= unpack_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
    end
  end

  // An empty FIFO keeps presenting the most recently delivered word.
  assign bus.win_ready = win_ready_s;
  assign bus.w_valid   = ~empty_s;
  assign bus.w_data    = empty_s ? hold_q[WORD_W-1:0] : rd_data_s[WORD_W-1:0];
  assign bus.w_round   = empty_s ? hold_q[TAG_W-1:WORD_W] : rd_data_s[TAG_W-1:WORD_W];
  assign bus.w_last    = ~empty_s & (rd_data_s[TAG_W-1:WORD_W] == LAST_RND);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sha256_w_window_reader.sv
// Directed bench for the window reader, using the "abc" message schedule as
// reference data and checking every delivered word against it.
module tb_sha256_w_window_reader;
  import sha256_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  sha256_w_window_reader_if bus ();

  sha256_w_window_reader #(
    .FIFO_DEPTH (8),
    .ROUNDS     (64)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] w_sched [64];
  logic [31:0] key = 32'h0;
  int          wi, rx, done_cnt, last_hs_cyc, n_offer;
  int          cyc = 0;
  int          stall_at = -1;
  int          stall_left = 0;
  int          spur_at = -1;
  bit          valid_on = 1'b0;
  bit          toggle_mode = 1'b0;
  bit          start_req = 1'b0;
  bit          prev_stall = 1'b0;
  logic [37:0] prev_out;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] exp_word(input int t);
    if (t < 64) return w_sched[t] ^ key;
    else        return 32'hDEAD0000 + 32'(t);
  endfunction

  function automatic logic [127:0] window(input int idx);
    int t;
    t = (idx == 0) ? 3 : idx + 3;
    return {exp_word(t - 3), exp_word(t - 2), exp_word(t - 1), exp_word(t)};
  endfunction

  // One clock: drive inputs at the falling edge, then score the transfers
  // that the next rising edge will perform.
  task automatic cycle();
    @(negedge CLK);
    cyc++;
    bus.start = start_req;
    start_req = 1'b0;
    if (spur_at >= 0 && rx == spur_at) begin
      bus.start = 1'b1;
      spur_at   = -1;
    end
    if (stall_at >= 0 && rx == stall_at) begin
      stall_left = 20;
      stall_at   = -1;
    end
    if (stall_left > 0) begin
      bus.w_ready = 1'b0;
      stall_left--;
      if (stall_left == 0) begin
        chk("bp_win_ready_low", 64'(bus.win_ready), 64'd0);
        chk("bp_w_valid", 64'(bus.w_valid), 64'd1);
      end
    end else begin
      bus.w_ready = 1'b1;
    end
    bus.win_valid = valid_on && (wi < n_offer) && (!toggle_mode || cyc[0]);
    bus.win_data  = window(wi);

    if (prev_stall) begin
      chk("stall_hold", {26'd0, bus.w_round, bus.w_data}, {26'd0, prev_out});
      chk("stall_valid", 64'(bus.w_valid), 64'd1);
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_timing", 64'(cyc - 1), 64'(last_hs_cyc));
    end
    if (wi >= 61 && bus.busy) begin
      chk("win_ready_sat", 64'(bus.win_ready), 64'd0);
    end
    if (bus.w_valid && bus.w_ready) begin
      chk("w_round", 64'(bus.w_round), 64'(rx[5:0]));
      chk("w_data", 64'(bus.w_data), 64'(exp_word(rx)));
      chk("w_last", 64'(bus.w_last), 64'(rx == 63));
      if (key == 32'h0 && rx == 0)  chk("abc_w0", 64'(bus.w_data), 64'h61626380);
      if (key == 32'h0 && rx == 16) chk("abc_w16", 64'(bus.w_data), 64'h61626380);
      if (key == 32'h0 && rx == 17) chk("abc_w17", 64'(bus.w_data), 64'h000F0000);
      rx++;
      last_hs_cyc = cyc;
    end
    if (bus.win_valid && bus.win_ready) wi++;
    prev_stall = bus.w_valid && !bus.w_ready;
    prev_out   = {bus.w_round, bus.w_data};
  endtask

  task automatic run_block(input int offer);
    wi = 0; rx = 0; done_cnt = 0; last_hs_cyc = -10;
    n_offer = offer; valid_on = 1'b1; start_req = 1'b1;
    for (int i = 0; i < 1000 && done_cnt == 0; i++) cycle();
    cycle();
    cycle();
    chk("block_words", 64'(rx), 64'd64);
    chk("block_windows", 64'(wi), 64'd61);
    chk("block_done_cnt", 64'(done_cnt), 64'd1);
    chk("block_idle", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    for (int t = 0; t < 16; t++) w_sched[t] = 32'h0;
    w_sched[0]  = 32'h61626380;
    w_sched[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      w_sched[t] = (ror(w_sched[t-2], 17) ^ ror(w_sched[t-2], 19) ^ (w_sched[t-2] >> 10))
                 + w_sched[t-7]
                 + (ror(w_sched[t-15], 7) ^ ror(w_sched[t-15], 18) ^ (w_sched[t-15] >> 3))
                 + w_sched[t-16];
    end
    bus.start = 1'b0; bus.win_valid = 1'b0; bus.win_data = 128'h0; bus.w_ready = 1'b0;

    // Reset state.
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
    chk("rst_win_ready", 64'(bus.win_ready), 64'd0);
    chk("rst_w_data", 64'(bus.w_data), 64'd0);
    chk("rst_w_last", 64'(bus.w_last), 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Windows offered while idle are not taken.
    wi = 0; rx = 0; n_offer = 70; valid_on = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_no_accept", 64'(wi), 64'd0);

    // Basic block, then backpressure, starved input, extra windows, spurious start.
    run_block(61);
    stall_at = 20;
    run_block(61);
    toggle_mode = 1'b1;
    run_block(61);
    toggle_mode = 1'b0;
    run_block(70);
    spur_at = 10;
    run_block(61);

    // Asynchronous reset in the middle of a block, then a fresh block.
    wi = 0; rx = 0; done_cnt = 0; n_offer = 70; valid_on = 1'b1; start_req = 1'b1;
    for (int i = 0; i < 500 && rx < 31; i++) cycle();
    chk("mid_reached_r30", 64'(rx), 64'd31);
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_w_valid", 64'(bus.w_valid), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_win_ready", 64'(bus.win_ready), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    prev_stall = 1'b0;
    key = 32'h5A5A5A5A;
    run_block(61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
